wb_irq_ctrl: RTL and testbench
==============================

# wb_irq_ctrl

Wishbone B3 slave interrupt controller that collects peripheral interrupt lines (UART and future peripherals), applies per-source polarity, optional edge latching and masking, and drives the 32-bit `irq_i` vector of the mor1kx CPU. It sits on the data-side Wishbone interconnect as one slave. Its output feeds the CPU interrupt input directly, replacing hard-wired per-bit IRQ assignments in the SoC top level.

## Interface
- `NUM_IRQ`, default 32: number of sources; valid range 1..32.
- `wb_clk_i`  in  1: system clock.
- `wb_rst_i`  in  1: reset; one clock, synchronous, active-high.
- `wb_adr_i`  in  8: byte address within the slave window; bits [1:0] are ignored.
- `wb_dat_i`  in  32: write data.
- `wb_sel_i`  in  4: byte enables; only selected bytes are written.
- `wb_we_i`  in  1: write enable.
- `wb_cyc_i`, `wb_stb_i`  in  1 each: bus cycle and strobe.
- `wb_cti_i`  in  3, `wb_bte_i`  in  2: accepted but not used; bursts are handled as classic cycles.
- `wb_dat_o`  out  32: read data.
- `wb_ack_o`, `wb_err_o`, `wb_rty_o`  out  1 each: termination signals; `wb_rty_o` is tied to 0.
- `irq_src_i`  in  NUM_IRQ: raw interrupt sources, synchronous to `wb_clk_i`.
- `irq_o`  out  32: CPU interrupt vector; bits at or above NUM_IRQ are 0.
- `int_o`  out  1: OR of `irq_o`.

## Operation
Register map (word offsets; bits at or above NUM_IRQ read 0 and ignore writes):
- 0x00 RAW, read-only: `lat | (~mode & lvl)`, where `lvl = src_q ^ pol`.
- 0x04 MASK, read/write: 1 = source enabled. Reset value 0.
- 0x08 PEND, read-only: `RAW & MASK`.
- 0x0C CLEAR, write-1-to-clear on `lat`; reads 0.
- 0x10 MODE, read/write: 1 = edge, 0 = level. Reset value 0.
- 0x14 POL, read/write: 1 = active-low / falling edge. Reset value 0.
- 0x18 SET, write-1-to-set on `lat` (software trigger); reads 0.
- 0x1C ID, read-only: `{23'h0, EDGE_PRESENT, 2'b0, NUM_IRQ[5:0]}`.

Source path:
- `src_q` registers `irq_src_i`; `src_qq` registers `src_q`.
- Active edge: `(src_q ^ pol) & ~(src_qq ^ pol) & mode`.
- Setting `lat` on an active edge or SET write has priority over CLEAR. If set and clear hit the same bit in the same cycle, the bit stays 1.
- Writing POL or MODE does not modify `lat`.

Bus:
- An access is `wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o`.
- Offsets 0x20..0xFF terminate with `wb_err_o` instead of `wb_ack_o`. No register changes; `wb_dat_o` = 0.

## Timing
- Reset values: all registers 0; `wb_ack_o`, `wb_err_o`, `wb_dat_o`, `irq_o`, `int_o` all 0.
- Bus termination is registered: `ack`/`err` assert the cycle after the access is seen and stay high exactly one cycle.
- A continuously asserted strobe produces one termination every 2 cycles.
- Writes take effect on the clock edge that asserts `ack`. `wb_dat_o` is valid in that same cycle.
- `irq_o` is registered: `irq_o <= PEND`.
- Level source: `irq_src_i` rises in cycle N, `irq_o` is high in cycle N+2.
- Edge source: `irq_src_i` rises in cycle N, `lat` is set at N+2, `irq_o` is high at N+3.
- A MASK or CLEAR write acked in cycle N takes effect on `irq_o` in cycle N+1.
- Reset asserted mid-transfer drops `ack` in the following cycle; the pending access is discarded.

## Configuration
- `WB_IRQ_CTRL_EDGE_EN` defined:
  - MODE register, `src_qq` and edge detection are implemented.
  - ID bit 8 = 1.
- `WB_IRQ_CTRL_EDGE_EN` undefined:
  - MODE reads 0 and ignores writes; all sources are level.
  - `lat` is set only by SET writes; `src_qq` is not instantiated.
  - ID bit 8 = 0.

## Structure
- Package `wb_irq_ctrl_pkg` holds:
  - register offset localparams (`IRQ_RAW`..`IRQ_ID`);
  - the ID layout;
  - the error-window boundary 0x20.
- Sub-module `wb_irq_ctrl_src` holds one source: sync flop, edge detect, `lat` set/clear, level term. Instantiate it NUM_IRQ times in a generate loop.
- The top level holds the bus decode, MASK/MODE/POL registers and the output register.

## Test plan
- Level, active-high: MASK=0x4, pulse `irq_src_i[2]` high for 5 cycles from N → `irq_o` = 0x4 for cycles N+2..N+6, then 0; `int_o` tracks it.
- Edge, POL: MODE=0x1, POL=0x1, drive `src[0]` 1→0 at N → PEND reads 0x1 from N+2 and stays set after `src[0]` returns to 1; CLEAR 0x1 → PEND = 0.
- Set/clear collision: edge on `src[3]` in the same cycle as a CLEAR write of 0x8 → RAW bit 3 = 1 afterwards.
- Byte lanes and error: write 0xFFFFFFFF to MASK with sel=4'b0010 → MASK = 0x0000FF00. Read offset 0x40 → `err` = 1, `ack` = 0, data = 0.
- Back-to-back bursts: hold `stb` with cti=3'b010 for 4 reads → one ack every 2 cycles, and ID = 0x120 with NUM_IRQ=32 and the macro defined.
- Reset mid-operation: assert reset while `irq_o` = 0x4 and an access is pending → next cycle all outputs are 0 and MASK reads 0.

Source files
------------

// File: rtl/wb_irq_ctrl_pkg.sv
// Shared register map, ID word layout and byte-lane helper for the Wishbone interrupt controller.
// Edge support is selected in the other files by WB_IRQ_CTRL_EDGE_EN.
package wb_irq_ctrl_pkg;

   localparam logic [7:0] IRQ_RAW   = 8'h00;
   localparam logic [7:0] IRQ_MASK  = 8'h04;
   localparam logic [7:0] IRQ_PEND  = 8'h08;
   localparam logic [7:0] IRQ_CLEAR = 8'h0C;
   localparam logic [7:0] IRQ_MODE  = 8'h10;
   localparam logic [7:0] IRQ_POL   = 8'h14;
   localparam logic [7:0] IRQ_SET   = 8'h18;
   localparam logic [7:0] IRQ_ID    = 8'h1C;

   // First byte offset that terminates with err instead of ack.
   localparam logic [7:0] IRQ_ERR_BASE = 8'h20;

   typedef struct packed {
      logic [22:0] rsvd_hi;
      logic        edge_present;
      logic [1:0]  rsvd_lo;
      logic [5:0]  num_irq;
   } irq_id_t;

   function automatic logic [31:0] id_word(input logic edge_present, input logic [5:0] num_irq);
      irq_id_t id;
      id              = '0;
      id.edge_present = edge_present;
      id.num_irq      = num_irq;
      return id;
   endfunction

   function automatic logic [31:0] byte_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/wb_irq_ctrl_src.sv
// One interrupt source: sync flop, sticky latch and level term.
// The second sync stage and edge detection exist only with WB_IRQ_CTRL_EDGE_EN.
module wb_irq_ctrl_src
   import wb_irq_ctrl_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_src,
   input  logic i_pol,
   input  logic i_mode,
   input  logic i_set,
   input  logic i_clr,
   output logic o_raw
);

   logic r_src_q;
   logic r_lat;
   logic w_lvl;
   logic w_edge;
   logic w_set;

   assign w_lvl = r_src_q ^ i_pol;
   assign w_set = w_edge | i_set;

   // A set in the same cycle as a clear wins, so no event is ever lost.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_src_q <= 1'b0;
         r_lat   <= 1'b0;
      end else begin
         r_src_q <= i_src;
         if (w_set)
            r_lat <= 1'b1;
         else if (i_clr)
            r_lat <= 1'b0;
      end
   end

`ifdef WB_IRQ_CTRL_EDGE_EN
   logic r_src_qq;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_src_qq <= 1'b0;
      else
         r_src_qq <= r_src_q;
   end

   assign w_edge = w_lvl & ~(r_src_qq ^ i_pol) & i_mode;
`else
   assign w_edge = 1'b0;
`endif

   assign o_raw = r_lat | (~i_mode & w_lvl);

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone B3 interrupt controller driving the mor1kx irq vector.
// Define WB_IRQ_CTRL_EDGE_EN to build the MODE register and edge-triggered sources.
module wb_irq_ctrl
   import wb_irq_ctrl_pkg::*;
#(
   parameter int NUM_IRQ = 32
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic [7:0]         wb_adr_i,
   input  logic [31:0]        wb_dat_i,
   input  logic [3:0]         wb_sel_i,
   input  logic               wb_we_i,
   input  logic               wb_cyc_i,
   input  logic               wb_stb_i,
   input  logic [2:0]         wb_cti_i,
   input  logic [1:0]         wb_bte_i,
   output logic [31:0]        wb_dat_o,
   output logic               wb_ack_o,
   output logic               wb_err_o,
   output logic               wb_rty_o,
   input  logic [NUM_IRQ-1:0] irq_src_i,
   output logic [31:0]        irq_o,
   output logic               int_o
);

   logic [NUM_IRQ-1:0] r_mask;
   logic [NUM_IRQ-1:0] r_pol;
   logic [NUM_IRQ-1:0] w_mode;
   logic [NUM_IRQ-1:0] w_raw;
   logic [NUM_IRQ-1:0] w_pend;
   logic [NUM_IRQ-1:0] w_set;
   logic [NUM_IRQ-1:0] w_clr;
   logic [NUM_IRQ-1:0] w_be_n;
   logic [NUM_IRQ-1:0] w_wdata_n;
   logic [31:0]        r_irq;
   logic [31:0]        r_dat;
   logic               r_ack;
   logic               r_err;
   logic [7:0]         w_addr;
   logic               w_bad;
   logic               w_access;
   logic               w_wr;
   logic [31:0]        w_be;
   logic [31:0]        w_wdata;
   logic [31:0]        w_rdata;
   logic               w_unused;

   assign w_unused  = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

   assign w_addr    = {wb_adr_i[7:2], 2'b00};
   assign w_bad     = (w_addr >= IRQ_ERR_BASE);
   assign w_access  = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
   assign w_wr      = w_access & wb_we_i & ~w_bad;
   assign w_be      = byte_mask(wb_sel_i);
   assign w_wdata   = wb_dat_i & w_be;
   assign w_be_n    = w_be[NUM_IRQ-1:0];
   assign w_wdata_n = w_wdata[NUM_IRQ-1:0];

   assign w_set  = (w_wr && (w_addr == IRQ_SET))   ? w_wdata_n : '0;
   assign w_clr  = (w_wr && (w_addr == IRQ_CLEAR)) ? w_wdata_n : '0;
   assign w_pend = w_raw & r_mask;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_mask <= '0;
         r_pol  <= '0;
      end else begin
         if (w_wr && (w_addr == IRQ_MASK))
            r_mask <= (r_mask & ~w_be_n) | w_wdata_n;
         if (w_wr && (w_addr == IRQ_POL))
            r_pol <= (r_pol & ~w_be_n) | w_wdata_n;
      end
   end

`ifdef WB_IRQ_CTRL_EDGE_EN
   localparam logic EDGE_PRESENT = 1'b1;
   logic [NUM_IRQ-1:0] r_mode;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         r_mode <= '0;
      else if (w_wr && (w_addr == IRQ_MODE))
         r_mode <= (r_mode & ~w_be_n) | w_wdata_n;
   end

   assign w_mode = r_mode;
`else
   localparam logic EDGE_PRESENT = 1'b0;
   assign w_mode = '0;
`endif

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
      wb_irq_ctrl_src u_src (
         .i_clk  (wb_clk_i),
         .i_rst  (wb_rst_i),
         .i_src  (irq_src_i[g]),
         .i_pol  (r_pol[g]),
         .i_mode (w_mode[g]),
         .i_set  (w_set[g]),
         .i_clr  (w_clr[g]),
         .o_raw  (w_raw[g])
      );
   end

   always_comb begin
      w_rdata = '0;
      case (w_addr)
         IRQ_RAW:  w_rdata = 32'(w_raw);
         IRQ_MASK: w_rdata = 32'(r_mask);
         IRQ_PEND: w_rdata = 32'(w_pend);
         IRQ_MODE: w_rdata = 32'(w_mode);
         IRQ_POL:  w_rdata = 32'(r_pol);
         IRQ_ID:   w_rdata = id_word(EDGE_PRESENT, 6'(NUM_IRQ));
         default:  w_rdata = '0;
      endcase
   end

   // Termination and read data are registered; data reflects state before a same-cycle write.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         r_dat <= '0;
         r_irq <= '0;
      end else begin
         r_ack <= w_access & ~w_bad;
         r_err <= w_access & w_bad;
         r_dat <= (w_access && !w_bad) ? w_rdata : '0;
         r_irq <= 32'(w_pend);
      end
   end

   assign wb_dat_o = r_dat;
   assign wb_ack_o = r_ack;
   assign wb_err_o = r_err;
   assign wb_rty_o = 1'b0;
   assign irq_o    = r_irq;
   assign int_o    = |r_irq;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Randomized, self-checking bench for wb_irq_ctrl; edge scenarios run only when
// WB_IRQ_CTRL_EDGE_EN is defined for the build.
module tb_wb_irq_ctrl;
   import wb_irq_ctrl_pkg::*;

   localparam int NUM_IRQ = 32;
`ifdef WB_IRQ_CTRL_EDGE_EN
   localparam logic [31:0] EXP_ID = 32'h0000_0120;
`else
   localparam logic [31:0] EXP_ID = 32'h0000_0020;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [7:0]         wb_adr_i;
   logic [31:0]        wb_dat_i;
   logic [3:0]         wb_sel_i;
   logic               wb_we_i, wb_cyc_i, wb_stb_i;
   logic [2:0]         wb_cti_i;
   logic [1:0]         wb_bte_i;
   logic [31:0]        wb_dat_o;
   logic               wb_ack_o, wb_err_o, wb_rty_o;
   logic [NUM_IRQ-1:0] irq_src_i;
   logic [31:0]        irq_o;
   logic               int_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
      .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .irq_src_i(irq_src_i), .irq_o(irq_o),
      .int_o(int_o)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Returns at #1 into the cycle that carries the termination.
   task automatic wb_xfer(input logic [7:0] addr, input logic we, input logic [31:0] data,
                          input logic [3:0] sel, output logic [31:0] rdata,
                          output logic got_ack, output logic got_err);
      bit done = 0;
      rdata = '0; got_ack = 0; got_err = 0;
      @(posedge clk); #1;
      wb_adr_i = addr; wb_we_i = we; wb_dat_i = data; wb_sel_i = sel;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      for (int i = 0; i < 8 && !done; i++) begin
         @(posedge clk); #1;
         if (wb_ack_o || wb_err_o) begin
            rdata = wb_dat_o; got_ack = wb_ack_o; got_err = wb_err_o; done = 1;
         end
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL bus_timeout addr=%h: no termination within 8 cycles", addr);
      end
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      logic [31:0] d; logic a, e;
      wb_xfer(addr, 1'b1, data, 4'hF, d, a, e);
   endtask

   task automatic rd(input logic [7:0] addr, output logic [31:0] data);
      logic a, e;
      wb_xfer(addr, 1'b0, 32'h0, 4'hF, data, a, e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({wb_ack_o, wb_err_o, wb_rty_o, int_o} !== 4'b0 || wb_dat_o !== 32'h0 || irq_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%b err=%b rty=%b int=%b dat=%h irq=%h, required all 0",
                  wb_ack_o, wb_err_o, wb_rty_o, int_o, wb_dat_o, irq_o);
      end
      rst = 1'b0;
      rd(IRQ_MASK, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h want 0", d); end
      rd(IRQ_POL, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_pol: got %h want 0", d); end
      rd(IRQ_MODE, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_mode: got %h want 0", d); end
      rd(IRQ_RAW, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_raw: got %h want 0", d); end
      rd(IRQ_ID, d); checks++;
      if (d !== EXP_ID) begin errors++; $display("FAIL id: got %h want %h", d, EXP_ID); end
   endtask

   task automatic test_level_pulse;
      logic [31:0] exp;
      irq_src_i = '0;
      wr(IRQ_MODE, 32'h0); wr(IRQ_POL, 32'h0); wr(IRQ_MASK, 32'h4); wr(IRQ_CLEAR, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      irq_src_i[2] = 1'b1;
      for (int k = 0; k < 9; k++) begin
         if (k == 5) irq_src_i[2] = 1'b0;
         @(negedge clk);
         exp = (k >= 2 && k <= 6) ? 32'h4 : 32'h0;
         checks++;
         if (irq_o !== exp || int_o !== (exp != 0)) begin
            errors++;
            $display("FAIL level_pulse N+%0d: irq=%h int=%b want irq=%h", k, irq_o, int_o, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_level_random;
      logic [31:0] pol, mask, v0, exp, d, s_last;
      logic [31:0] s [0:63];
      pol = $urandom; mask = $urandom; v0 = irq_src_i;
      wr(IRQ_MODE, 32'h0); wr(IRQ_POL, pol); wr(IRQ_MASK, mask); wr(IRQ_CLEAR, 32'hFFFF_FFFF);
      for (int t = 0; t < 64; t++) begin
         @(posedge clk); #1;
         s[t] = $urandom;
         irq_src_i = s[t];
         @(negedge clk);
         exp = (((t >= 2) ? s[t-2] : v0) ^ pol) & mask;
         checks++;
         if (irq_o !== exp || int_o !== (exp != 0)) begin
            errors++;
            $display("FAIL level_random t=%0d: irq=%h int=%b want %h", t, irq_o, int_o, exp);
         end
      end
      s_last = s[63];
      idle(3);
      rd(IRQ_RAW, d); checks++;
      if (d !== (s_last ^ pol)) begin errors++; $display("FAIL level_raw: got %h want %h", d, s_last ^ pol); end
      rd(IRQ_PEND, d); checks++;
      if (d !== ((s_last ^ pol) & mask)) begin
         errors++; $display("FAIL level_pend: got %h want %h", d, (s_last ^ pol) & mask);
      end
   endtask

   task automatic test_set_clear;
      logic [31:0] d;
      irq_src_i = '0;
      wr(IRQ_MODE, 32'h0); wr(IRQ_POL, 32'h0); wr(IRQ_MASK, 32'h0F0); wr(IRQ_CLEAR, 32'hFFFF_FFFF);
      idle(3);
      wr(IRQ_SET, 32'h130);
      rd(IRQ_RAW, d); checks++;
      if (d !== 32'h130) begin errors++; $display("FAIL set_raw: got %h want 130", d); end
      rd(IRQ_PEND, d); checks++;
      if (d !== 32'h030) begin errors++; $display("FAIL set_pend: got %h want 030", d); end
      wr(IRQ_POL, 32'h10); wr(IRQ_POL, 32'h0);
      idle(3);
      rd(IRQ_RAW, d); checks++;
      if (d !== 32'h130) begin errors++; $display("FAIL pol_keeps_lat: got %h want 130", d); end
      wr(IRQ_CLEAR, 32'h110);
      rd(IRQ_RAW, d); checks++;
      if (d !== 32'h020) begin errors++; $display("FAIL clear_raw: got %h want 020", d); end
      begin
         logic a, e;
         wb_xfer(IRQ_SET, 1'b1, 32'hFFFF_FFFF, 4'b0001, d, a, e);
      end
      rd(IRQ_RAW, d); checks++;
      if (d !== 32'h0FF) begin errors++; $display("FAIL set_bytelane: got %h want 0FF", d); end
      rd(IRQ_SET, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL set_reads0: got %h want 0", d); end
      wr(IRQ_CLEAR, 32'hFFFF_FFFF);
   endtask

   task automatic test_mask_timing;
      logic [31:0] d; logic a, e;
      irq_src_i = '0; irq_src_i[1] = 1'b1;
      wr(IRQ_MODE, 32'h0); wr(IRQ_POL, 32'h0); wr(IRQ_MASK, 32'h0); wr(IRQ_CLEAR, 32'hFFFF_FFFF);
      idle(3);
      wb_xfer(IRQ_MASK, 1'b1, 32'h102, 4'hF, d, a, e);
      checks++;
      if (irq_o !== 32'h0) begin errors++; $display("FAIL mask_ack_cycle: irq=%h want 0", irq_o); end
      @(posedge clk); #1; checks++;
      if (irq_o !== 32'h2) begin errors++; $display("FAIL mask_next_cycle: irq=%h want 2", irq_o); end
      wr(IRQ_SET, 32'h100);
      idle(2); checks++;
      if (irq_o !== 32'h102) begin errors++; $display("FAIL set_irq: irq=%h want 102", irq_o); end
      wb_xfer(IRQ_CLEAR, 1'b1, 32'h100, 4'hF, d, a, e);
      checks++;
      if (irq_o !== 32'h102) begin errors++; $display("FAIL clear_ack_cycle: irq=%h want 102", irq_o); end
      @(posedge clk); #1; checks++;
      if (irq_o !== 32'h2) begin errors++; $display("FAIL clear_next_cycle: irq=%h want 2", irq_o); end
   endtask

   task automatic test_bytes_err;
      logic [31:0] d; logic a, e;
      wr(IRQ_MASK, 32'h0);
      wb_xfer(IRQ_MASK, 1'b1, 32'hFFFF_FFFF, 4'b0010, d, a, e);
      rd(IRQ_MASK, d); checks++;
      if (d !== 32'h0000_FF00) begin errors++; $display("FAIL mask_bytelane: got %h want 0000ff00", d); end
      wb_xfer(8'h40, 1'b0, 32'h0, 4'hF, d, a, e); checks++;
      if (e !== 1'b1 || a !== 1'b0 || d !== 32'h0) begin
         errors++; $display("FAIL err_read40: err=%b ack=%b dat=%h want err=1 ack=0 dat=0", e, a, d);
      end
      wb_xfer(8'h20, 1'b0, 32'h0, 4'hF, d, a, e); checks++;
      if (e !== 1'b1 || a !== 1'b0) begin errors++; $display("FAIL err_boundary20: err=%b ack=%b want err=1", e, a); end
      wb_xfer(8'h44, 1'b1, 32'h0, 4'hF, d, a, e); checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL err_write44: err=%b want 1", e); end
      rd(IRQ_MASK, d); checks++;
      if (d !== 32'h0000_FF00) begin errors++; $display("FAIL err_no_write: mask=%h want 0000ff00", d); end
      wb_xfer(8'h1F, 1'b0, 32'h0, 4'hF, d, a, e); checks++;
      if (a !== 1'b1 || d !== EXP_ID) begin errors++; $display("FAIL id_low_bits: ack=%b dat=%h want ack=1 dat=%h", a, d, EXP_ID); end
   endtask

   task automatic test_back_to_back;
      int acks = 0;
      @(posedge clk); #1;
      wb_adr_i = IRQ_ID; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cti_i = 3'b010;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         checks++;
         if (wb_ack_o !== logic'(k % 2) || wb_err_o !== 1'b0 || (wb_ack_o && wb_dat_o !== EXP_ID)) begin
            errors++;
            $display("FAIL burst cycle %0d: ack=%b err=%b dat=%h want ack=%0d dat=%h",
                     k, wb_ack_o, wb_err_o, wb_dat_o, k % 2, EXP_ID);
         end
         if (wb_ack_o) acks++;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b000;
      checks++;
      if (acks != 4) begin errors++; $display("FAIL burst_ack_count: got %0d want 4", acks); end
   endtask

   task automatic test_mode_cfg;
      logic [31:0] d;
      wr(IRQ_MODE, 32'h0000_00A5);
      rd(IRQ_MODE, d); checks++;
`ifdef WB_IRQ_CTRL_EDGE_EN
      if (d !== 32'h0000_00A5) begin errors++; $display("FAIL mode_rw: got %h want 000000a5", d); end
`else
      if (d !== 32'h0) begin errors++; $display("FAIL mode_rw: got %h want 0", d); end
`endif
      wr(IRQ_MODE, 32'h0);
   endtask

`ifdef WB_IRQ_CTRL_EDGE_EN
   task automatic test_edge_plan;
      logic [31:0] d, exp;
      irq_src_i = 32'h1;
      wr(IRQ_MASK, 32'h1); wr(IRQ_POL, 32'h1); wr(IRQ_MODE, 32'h1);
      idle(3);
      wr(IRQ_CLEAR, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      irq_src_i[0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         exp = (k >= 3) ? 32'h1 : 32'h0;
         checks++;
         if (irq_o !== exp) begin errors++; $display("FAIL edge_fall N+%0d: irq=%h want %h", k, irq_o, exp); end
         @(posedge clk); #1;
      end
      irq_src_i[0] = 1'b1;
      idle(3);
      rd(IRQ_PEND, d); checks++;
      if (d !== 32'h1) begin errors++; $display("FAIL edge_sticky: pend=%h want 1", d); end
      wr(IRQ_CLEAR, 32'h1);
      rd(IRQ_PEND, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL edge_clear: pend=%h want 0", d); end
   endtask

   task automatic test_edge_random;
      logic [31:0] pol, mask, v0, sticky, sn, sp, exp;
      logic [31:0] s [0:79];
      pol = $urandom; mask = $urandom; v0 = irq_src_i; sticky = '0;
      wr(IRQ_MODE, 32'hFFFF_FFFF); wr(IRQ_POL, pol); wr(IRQ_MASK, mask);
      idle(3);
      wr(IRQ_CLEAR, 32'hFFFF_FFFF);
      for (int t = 0; t < 80; t++) begin
         @(posedge clk); #1;
         s[t] = ((t > 0) ? s[t-1] : v0) ^ ($urandom & $urandom & $urandom);
         irq_src_i = s[t];
         sn = (t >= 3) ? s[t-3] : v0;
         sp = (t >= 4) ? s[t-4] : v0;
         sticky = sticky | ((sn ^ pol) & ~(sp ^ pol));
         exp = sticky & mask;
         @(negedge clk);
         checks++;
         if (irq_o !== exp || int_o !== (exp != 0)) begin
            errors++; $display("FAIL edge_random t=%0d: irq=%h int=%b want %h", t, irq_o, int_o, exp);
         end
      end
   endtask

   task automatic test_collision;
      logic [31:0] d; logic a, e;
      irq_src_i = '0;
      wr(IRQ_POL, 32'h0); wr(IRQ_MODE, 32'h8); wr(IRQ_MASK, 32'h8);
      idle(3);
      wr(IRQ_CLEAR, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      irq_src_i[3] = 1'b1;
      wb_xfer(IRQ_CLEAR, 1'b1, 32'h8, 4'hF, d, a, e);
      rd(IRQ_RAW, d); checks++;
      if (d[3] !== 1'b1) begin errors++; $display("FAIL collision_set_wins: raw=%h want bit3=1", d); end
      wr(IRQ_CLEAR, 32'h8);
      rd(IRQ_RAW, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL collision_later_clear: raw=%h want 0", d); end
      wr(IRQ_MODE, 32'h0);
   endtask
`endif

   task automatic test_reset_mid;
      logic [31:0] d;
      irq_src_i = '0; irq_src_i[2] = 1'b1;
      wr(IRQ_MODE, 32'h0); wr(IRQ_POL, 32'h0); wr(IRQ_CLEAR, 32'hFFFF_FFFF); wr(IRQ_MASK, 32'h4);
      idle(3); checks++;
      if (irq_o !== 32'h4) begin errors++; $display("FAIL reset_mid_pre: irq=%h want 4", irq_o); end
      wb_adr_i = IRQ_MASK; wb_we_i = 1'b0; wb_sel_i = 4'hF;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; rst = 1'b1;
      @(posedge clk); #1; checks++;
      if ({wb_ack_o, wb_err_o, int_o} !== 3'b0 || wb_dat_o !== 32'h0 || irq_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_outputs: ack=%b err=%b int=%b dat=%h irq=%h want all 0",
                  wb_ack_o, wb_err_o, int_o, wb_dat_o, irq_o);
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; rst = 1'b0;
      rd(IRQ_MASK, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_mid_mask: got %h want 0", d); end
      idle(2); checks++;
      if (irq_o !== 32'h0) begin errors++; $display("FAIL reset_mid_irq: irq=%h want 0", irq_o); end
   endtask

   initial begin
      rst = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = '0; wb_bte_i = '0; irq_src_i = '0;
      test_reset();
      test_level_pulse();
      test_level_random();
      test_set_clear();
      test_mask_timing();
      test_bytes_err();
      test_back_to_back();
      test_mode_cfg();
`ifdef WB_IRQ_CTRL_EDGE_EN
      test_edge_plan();
      test_edge_random();
      test_collision();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
